mem_responder: RTL and testbench

- Word-organised memory slave for the CPU's memory port (mem_address / mem_rdata / mem_wdata, with read/write/byte-enable/resp handshake).
- Accepts one request at a time and stores it. Waits a programmable number of cycles, then completes the access against an internal word array and pulses mem_resp.
- Used as the behavioural/synthesizable backing store for CPU bring-up and as the responder model in datapath benches.

---
 rtl/mem_if.sv | 22 ++
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// Memory-port bundle between an initiator (CPU or bench) and a word-organised responder.
// Requests are held by the master until the single-cycle mem_resp pulse.
interface mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp, mem_err
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp, mem_err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised memory slave: captures one request, waits LATENCY cycles from
// acceptance, then completes the access against an internal array and pulses mem_resp.
module mem_responder #(
    parameter int          DEPTH_LOG2 = 8,
    parameter int          LATENCY    = 3,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    mem_if.slave mem
);
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              count_reg, count_next;
    logic                    is_write_reg;
    logic                    err_reg;
    logic                    in_range_reg;
    logic [DEPTH_LOG2-1:0]   index_reg;
    logic [31:0]             wdata_reg;
    logic [3:0]              be_reg;
    logic [31:0]             rdata_reg;
    logic [3:0]              lane_we;

    logic [31:0] mem_array [DEPTH];

    logic                  req_seen;
    logic                  accept;
    logic                  in_range_live;
    logic [DEPTH_LOG2-1:0] index_live;
    logic                  unused_addr_bits;

    assign req_seen         = mem.mem_read | mem.mem_write;
    assign accept           = (state_reg == IDLE) && req_seen;
    assign in_range_live    = (mem.mem_address[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    assign index_live       = mem.mem_address[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^mem.mem_address[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (req_seen) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        count_next = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (count_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture; read+write together is flagged as an error but handled as a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_write_reg <= 1'b0;
            err_reg      <= 1'b0;
            in_range_reg <= 1'b0;
            index_reg    <= '0;
            wdata_reg    <= 32'd0;
            be_reg       <= 4'd0;
        end else if (accept) begin
            is_write_reg <= mem.mem_write;
            err_reg      <= ~in_range_live | (mem.mem_read & mem.mem_write);
            in_range_reg <= in_range_live;
            index_reg    <= index_live;
            wdata_reg    <= mem.mem_wdata;
            be_reg       <= mem.mem_byte_enable;
        end
    end

    // With LATENCY==1 RESP is entered on the same edge as capture, so use live request fields.
    logic                  op_write_now;
    logic                  in_range_now;
    logic [DEPTH_LOG2-1:0] index_now;

    assign op_write_now = (state_reg == IDLE) ? mem.mem_write : is_write_reg;
    assign in_range_now = (state_reg == IDLE) ? in_range_live : in_range_reg;
    assign index_now    = (state_reg == IDLE) ? index_live    : index_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= 32'd0;
        end else if ((state_next == RESP) && (state_reg != RESP) && !op_write_now) begin
            rdata_reg <= in_range_now ? mem_array[index_now] : 32'd0;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = (state_reg == RESP) && is_write_reg && in_range_reg && be_reg[gi];
        end
    endgenerate

    // Array is intentionally not reset; the write commits at the end of the RESP cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem_array[index_reg][8*i +: 8] <= wdata_reg[8*i +: 8];
            end
        end
    end

    assign mem.mem_rdata = rdata_reg;
    assign mem.mem_resp  = (state_reg == RESP);
    assign mem.mem_err   = (state_reg == RESP) && err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=3 instance and one LATENCY=1 instance
// sharing clock and reset.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    mem_if ifa ();
    mem_if ifb ();

    mem_responder #(.DEPTH_LOG2(8), .LATENCY(3), .BASE_ADDR(32'h0)) dut_a (
        .clk (clk),
        .rst (rst),
        .mem (ifa.slave)
    );

    mem_responder #(.DEPTH_LOG2(8), .LATENCY(1), .BASE_ADDR(32'h0)) dut_b (
        .clk (clk),
        .rst (rst),
        .mem (ifb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? ifb.mem_rdata : ifa.mem_rdata;
    endfunction

    function automatic logic get_resp(input bit sel);
        return sel ? ifb.mem_resp : ifa.mem_resp;
    endfunction

    function automatic logic get_err(input bit sel);
        return sel ? ifb.mem_err : ifa.mem_err;
    endfunction

    task automatic drive(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        if (sel) begin
            ifb.mem_read = rd; ifb.mem_write = wr; ifb.mem_address = addr;
            ifb.mem_wdata = wdata; ifb.mem_byte_enable = be;
        end else begin
            ifa.mem_read = rd; ifa.mem_write = wr; ifa.mem_address = addr;
            ifa.mem_wdata = wdata; ifa.mem_byte_enable = be;
        end
    endtask

    // One complete access: resp must appear exactly LAT cycles after the request cycle.
    task automatic req(input bit sel, input int lat, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        @(negedge clk);
        drive(sel, rd, wr, addr, wdata, be);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) chk({tag, ".early_resp"}, 32'(get_resp(sel)), 32'd0);
        end
        chk({tag, ".resp"}, 32'(get_resp(sel)), 32'd1);
        chk({tag, ".err"}, 32'(get_err(sel)), 32'(exp_err));
        if (rd && !wr) chk({tag, ".rdata"}, get_rdata(sel), exp_rdata);
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        chk({tag, ".pulse_end"}, 32'(get_resp(sel)), 32'd0);
        if (rd && !wr) chk({tag, ".rdata_hold"}, get_rdata(sel), exp_rdata);
        $display("txn %s dut=%0d rd=%0b wr=%0b addr=%h wdata=%h be=%h rdata=%h", tag, sel, rd, wr,
                 addr, wdata, be, get_rdata(sel));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle.a_resp", 32'(ifa.mem_resp), 32'd0);
            chk("idle.a_err", 32'(ifa.mem_err), 32'd0);
            chk("idle.a_rdata", ifa.mem_rdata, 32'd0);
            chk("idle.b_resp", 32'(ifb.mem_resp), 32'd0);
        end
        $display("txn idle: 10 cycles after reset");

        // Full-word write, then read with low address bits set.
        req(1'b0, 3, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, "wr_10");
        req(1'b0, 3, 1'b1, 1'b0, 32'h13, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, "rd_13");

        // Byte lanes 0 and 2 only, then an empty-mask write.
        req(1'b0, 3, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'd0, 1'b0, "wr_be5");
        req(1'b0, 3, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDE22BE44, 1'b0, "rd_be5");
        req(1'b0, 3, 1'b0, 1'b1, 32'h10, 32'h55667788, 4'b0000, 32'd0, 1'b0, "wr_be0");
        req(1'b0, 3, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDE22BE44, 1'b0, "rd_be0");

        // Out-of-range accesses must not alias onto word 0.
        req(1'b0, 3, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'd0, 1'b0, "wr_0");
        req(1'b0, 3, 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1, "wr_400");
        req(1'b0, 3, 1'b1, 1'b0, 32'h0, 32'd0, 4'h0, 32'h0BADF00D, 1'b0, "rd_0");
        req(1'b0, 3, 1'b1, 1'b0, 32'h400, 32'd0, 4'h0, 32'h0, 1'b1, "rd_400");

        // Read and write together: flagged, but the write still lands.
        req(1'b0, 3, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'd0, 1'b1, "rdwr_20");
        req(1'b0, 3, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0, "rd_20");

        // Reset one cycle after acceptance aborts the write.
        req(1'b0, 3, 1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0, "wr_30");
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h1, 4'hF);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.rdata_reset", ifa.mem_rdata, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort.no_resp", 32'(ifa.mem_resp), 32'd0);
        end
        $display("txn abort: write 0x30 cut by reset");
        req(1'b0, 3, 1'b1, 1'b0, 32'h30, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0, "rd_30");

        // LATENCY=1 instance: single-cycle turnaround and back-to-back reads.
        req(1'b1, 1, 1'b0, 1'b1, 32'h0, 32'h11111111, 4'hF, 32'd0, 1'b0, "b_wr_0");
        req(1'b1, 1, 1'b0, 1'b1, 32'h4, 32'h22222222, 4'hF, 32'd0, 1'b0, "b_wr_4");
        req(1'b1, 1, 1'b1, 1'b0, 32'h4, 32'd0, 4'h0, 32'h22222222, 1'b0, "b_rd_4");

        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 4'h0);
        @(negedge clk);
        chk("b2b.resp1", 32'(ifb.mem_resp), 32'd1);
        chk("b2b.rdata1", ifb.mem_rdata, 32'h11111111);
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'd0, 4'h0);
        @(negedge clk);
        chk("b2b.gap", 32'(ifb.mem_resp), 32'd0);
        chk("b2b.hold", ifb.mem_rdata, 32'h11111111);
        @(negedge clk);
        chk("b2b.resp2", 32'(ifb.mem_resp), 32'd1);
        chk("b2b.rdata2", ifb.mem_rdata, 32'h22222222);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        @(negedge clk);
        chk("b2b.end", 32'(ifb.mem_resp), 32'd0);
        $display("txn b2b: reads 0x0,0x4 back-to-back on LATENCY=1");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
